// File: rtl/vout_pkg.sv
// Shared types and defaults for the NTSC video output line encoder.
// Holds the FSM state enum, default timing/level constants, the line
// alignment preamble and the nibble-to-luminance helper.
package vout_pkg;

  typedef enum logic {WAIT_FILL = 1'b0, RUN = 1'b1} state_e;

  localparam int unsigned DefHTotal     = 400;
  localparam int unsigned DefHSync      = 30;
  localparam int unsigned DefHActStart  = 60;
  localparam int unsigned DefHActLen    = 320;
  localparam int unsigned DefVTotal     = 262;
  localparam int unsigned DefVSyncLines = 3;
  localparam int unsigned DefVActStart  = 20;
  localparam int unsigned DefVActLen    = 240;
  localparam int unsigned DefPrefill    = 256;
  localparam int unsigned DefLevelBlack = 16;
  localparam int unsigned DefLevelStep  = 15;

  localparam int unsigned FifoDataW = 4;
  localparam int unsigned FifoUsedW = 9;

  // Alignment preamble at the start of every active line: codes F,0,F,0.
  // Nibble i of the preamble lives in bits [4*i +: 4].
  localparam int unsigned PreLen      = 4;
  localparam logic [15:0] PreambleNibs = 16'h0F0F;

  // Luminance for a 4-bit code, wrapping in 8 bits.
  function automatic logic [7:0] nib_level(input logic [3:0] code, input int unsigned black,
                                           input int unsigned step);
    return 8'(black) + 8'(code) * 8'(step);
  endfunction

endpackage

// File: rtl/vout_line_encoder_if.sv
// Read side of the video output FIFO (normal mode: q valid one clock after rdreq).
//   fifor_data        FIFO q
//   fifor_empty       read-side empty
//   fifor_used_words  read-side fill level
//   fifor_acknowledge rdreq
// master: the consumer (encoder); slave: the FIFO.
interface vout_line_encoder_if;
  import vout_pkg::*;

  logic [FifoDataW-1:0] fifor_data;
  logic                 fifor_empty;
  logic [FifoUsedW-1:0] fifor_used_words;
  logic                 fifor_acknowledge;

  modport master (
    input  fifor_data,
    input  fifor_empty,
    input  fifor_used_words,
    output fifor_acknowledge
  );

  modport slave (
    output fifor_data,
    output fifor_empty,
    output fifor_used_words,
    input  fifor_acknowledge
  );

endinterface

// File: rtl/vout_timing.sv
// Horizontal/vertical raster counters and position decode.
//   i_clk, i_rst_n   pixel clock, synchronous active-low reset
//   o_sync           composite sync for the current position (active-low)
//   o_pre            position is in the line preamble of an active line
//   o_pre_idx        preamble nibble index 0..3
//   o_data           position is a data pixel
//   o_field_start    h==0, v==0
//   o_field_end      last clock of the field
module vout_timing
  import vout_pkg::*;
#(
  parameter int unsigned H_TOTAL      = DefHTotal,
  parameter int unsigned H_SYNC       = DefHSync,
  parameter int unsigned H_ACT_START  = DefHActStart,
  parameter int unsigned H_ACT_LEN    = DefHActLen,
  parameter int unsigned V_TOTAL      = DefVTotal,
  parameter int unsigned V_SYNC_LINES = DefVSyncLines,
  parameter int unsigned V_ACT_START  = DefVActStart,
  parameter int unsigned V_ACT_LEN    = DefVActLen
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_sync,
  output logic       o_pre,
  output logic [1:0] o_pre_idx,
  output logic       o_data,
  output logic       o_field_start,
  output logic       o_field_end
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_last, w_v_last, w_v_act, w_h_act, w_h_pre;

  assign w_h_last = (r_h == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v == VW'(V_TOTAL - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // Broad-sync lines hold sync low for all but the last H_SYNC clocks.
  assign o_sync = (r_v < VW'(V_SYNC_LINES)) ? (r_h >= HW'(H_TOTAL - H_SYNC))
                                             : (r_h >= HW'(H_SYNC));

  assign w_v_act = (r_v >= VW'(V_ACT_START)) && (r_v < VW'(V_ACT_START + V_ACT_LEN));
  assign w_h_act = (r_h >= HW'(H_ACT_START)) && (r_h < HW'(H_ACT_START + H_ACT_LEN));
  assign w_h_pre = (r_h < HW'(H_ACT_START + PreLen));

  assign o_pre         = w_v_act && w_h_act && w_h_pre;
  assign o_data        = w_v_act && w_h_act && !w_h_pre;
  assign o_pre_idx     = 2'(r_h - HW'(H_ACT_START));
  assign o_field_start = (r_h == '0) && (r_v == '0);
  assign o_field_end   = w_h_last && w_v_last;

endmodule

// File: rtl/vout_line_encoder.sv
// Pixel-clock stage between the video output FIFO and the DAC / composite sync.
// Arms a field only when the FIFO holds PREFILL nibbles at field start, reads
// one nibble per data pixel, and blanks the rest of the field on underrun.
//   i_clk, i_rst_n    pixel clock, synchronous active-low reset
//   io_fifo           FIFO read port (master side)
//   o_video_out       8-bit DAC level, 2 clocks after the raster position
//   o_sync            composite sync (active-low), same 2-clock alignment
//   o_field_active    current field is armed
//   o_underrun        sticky mid-field underrun flag
module vout_line_encoder
  import vout_pkg::*;
#(
  parameter int unsigned H_TOTAL      = DefHTotal,
  parameter int unsigned H_SYNC       = DefHSync,
  parameter int unsigned H_ACT_START  = DefHActStart,
  parameter int unsigned H_ACT_LEN    = DefHActLen,
  parameter int unsigned V_TOTAL      = DefVTotal,
  parameter int unsigned V_SYNC_LINES = DefVSyncLines,
  parameter int unsigned V_ACT_START  = DefVActStart,
  parameter int unsigned V_ACT_LEN    = DefVActLen,
  parameter int unsigned PREFILL      = DefPrefill,
  parameter int unsigned LEVEL_BLACK  = DefLevelBlack,
  parameter int unsigned LEVEL_STEP   = DefLevelStep
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  vout_line_encoder_if.master        io_fifo,
  output logic [7:0]                 o_video_out,
  output logic                       o_sync,
  output logic                       o_field_active,
  output logic                       o_underrun
);

  logic       w_sync, w_pre, w_data, w_field_start, w_field_end;
  logic [1:0] w_pre_idx;
  logic       w_run, w_ack, w_urun, w_arm;

  state_e     r_state;
  logic       r_underrun;
  // Stage 1: position info aligned with the FIFO q becoming valid.
  logic       r1_sync, r1_ack, r1_pre_on;
  logic [3:0] r1_pre_code;
  // Stage 2: output registers.
  logic [7:0] r_video;
  logic       r_sync;

  vout_timing #(
    .H_TOTAL      (H_TOTAL),
    .H_SYNC       (H_SYNC),
    .H_ACT_START  (H_ACT_START),
    .H_ACT_LEN    (H_ACT_LEN),
    .V_TOTAL      (V_TOTAL),
    .V_SYNC_LINES (V_SYNC_LINES),
    .V_ACT_START  (V_ACT_START),
    .V_ACT_LEN    (V_ACT_LEN)
  ) u_timing (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_sync        (w_sync),
    .o_pre         (w_pre),
    .o_pre_idx     (w_pre_idx),
    .o_data        (w_data),
    .o_field_start (w_field_start),
    .o_field_end   (w_field_end)
  );

  assign w_run  = (r_state == RUN);
  assign w_ack  = w_run && w_data && !io_fifo.fifor_empty;
  assign w_urun = w_run && w_data && io_fifo.fifor_empty;
  assign w_arm  = w_field_start && (io_fifo.fifor_used_words >= FifoUsedW'(PREFILL));

  assign io_fifo.fifor_acknowledge = w_ack;

  // Field FSM and sticky underrun. Leaving RUN on underrun blanks the rest of
  // the field because no further acks or preamble levels are produced.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= WAIT_FILL;
      r_underrun <= 1'b0;
    end else begin
      unique case (r_state)
        WAIT_FILL: if (w_arm) r_state <= RUN;
        RUN:       if (w_field_end || w_urun) r_state <= WAIT_FILL;
      endcase
      if (w_urun) r_underrun <= 1'b1;
    end
  end

  // Two-stage alignment: ack at t, FIFO q at t+1, DAC level at t+2.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r1_sync     <= 1'b1;
      r1_ack      <= 1'b0;
      r1_pre_on   <= 1'b0;
      r1_pre_code <= '0;
      r_video     <= 8'(LEVEL_BLACK);
      r_sync      <= 1'b1;
    end else begin
      r1_sync     <= w_sync;
      r1_ack      <= w_ack;
      r1_pre_on   <= w_run && w_pre;
      r1_pre_code <= PreambleNibs[{w_pre_idx, 2'b00} +: 4];
      if (r1_ack) begin
        r_video <= nib_level(io_fifo.fifor_data, LEVEL_BLACK, LEVEL_STEP);
      end else if (r1_pre_on) begin
        r_video <= nib_level(r1_pre_code, LEVEL_BLACK, LEVEL_STEP);
      end else begin
        r_video <= 8'(LEVEL_BLACK);
      end
      r_sync <= r1_sync;
    end
  end

  assign o_video_out    = r_video;
  assign o_sync         = r_sync;
  assign o_field_active = w_run;
  assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_vout_line_encoder.sv
module tb_vout_line_encoder;
  import vout_pkg::*;

  // Full horizontal timing; the field is shortened to keep runs short.
  localparam int unsigned HT = 400, HS = 30, HAS = 60, HAL = 320;
  localparam int unsigned VT = 24, VS = 3, VAS = 6, VAL = 16;
  localparam int unsigned PF = 256, LB = 16, LS = 15;
  localparam int unsigned FIELD = HT * VT;

  typedef struct {
    logic [7:0] v;
    logic       s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] video;
  logic       sync, fact, urun;
  logic [3:0] fifo_nib = 4'd0;

  always #5 clk = ~clk;

  vout_line_encoder_if u_if();

  vout_line_encoder #(
    .H_TOTAL      (HT),
    .H_SYNC       (HS),
    .H_ACT_START  (HAS),
    .H_ACT_LEN    (HAL),
    .V_TOTAL      (VT),
    .V_SYNC_LINES (VS),
    .V_ACT_START  (VAS),
    .V_ACT_LEN    (VAL),
    .PREFILL      (PF),
    .LEVEL_BLACK  (LB),
    .LEVEL_STEP   (LS)
  ) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .io_fifo        (u_if.master),
    .o_video_out    (video),
    .o_sync         (sync),
    .o_field_active (fact),
    .o_underrun     (urun)
  );

  // Normal-mode FIFO read side: nibbles 0..15 repeating, q valid 1 clk after rdreq.
  always @(posedge clk) begin
    if (u_if.fifor_acknowledge === 1'b1) begin
      u_if.fifor_data <= fifo_nib;
      fifo_nib        <= fifo_nib + 4'd1;
    end
  end

  // Reference model and scoreboard.
  int         mh, mv;
  state_e     mst;
  bit         mund;
  logic [3:0] mnib;
  exp_t       q[$];
  int         checks, errors;
  int         ack_cnt, sync_low_cnt, a0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s at h=%0d v=%0d: observed %0d expected %0d", tag, mh, mv, obs, exp_v);
    end
  endtask

  task automatic reset_model();
    exp_t r;
    mh   = 0;
    mv   = 0;
    mst  = WAIT_FILL;
    mund = 1'b0;
    r.v  = 8'(LB);
    r.s  = 1'b1;
    q.delete();
    q.push_back(r);
    q.push_back(r);
  endtask

  task automatic tick();
    exp_t e;
    bit   vact, dpix, ppix, eack, eurun;
    @(negedge clk);
    vact  = (mv >= VAS) && (mv < VAS + VAL);
    dpix  = vact && (mh >= HAS + 4) && (mh < HAS + HAL);
    ppix  = vact && (mh >= HAS) && (mh < HAS + 4);
    eack  = (mst == RUN) && dpix && (u_if.fifor_empty === 1'b0);
    eurun = (mst == RUN) && dpix && (u_if.fifor_empty === 1'b1);
    check("ack", 32'(u_if.fifor_acknowledge), 32'(eack));
    check("field_active", 32'(fact), 32'(mst == RUN));
    check("underrun", 32'(urun), 32'(mund));
    e = q.pop_front();
    check("video_out", 32'(video), 32'(e.v));
    check("sync", 32'(sync), 32'(e.s));
    if (u_if.fifor_acknowledge === 1'b1) ack_cnt++;
    if (sync === 1'b0) sync_low_cnt++;
    // Expected output for the current raster position.
    e.s = (mv < VS) ? (mh >= HT - HS) : (mh >= HS);
    if (eack) begin
      e.v  = 8'(LB + LS * int'(mnib));
      mnib = mnib + 4'd1;
    end else if ((mst == RUN) && ppix) begin
      e.v = (((mh - HAS) % 2) == 0) ? 8'd241 : 8'(LB);
    end else begin
      e.v = 8'(LB);
    end
    q.push_back(e);
    if (!rst_n) begin
      reset_model();
    end else begin
      if (eurun) mund = 1'b1;
      if (mst == WAIT_FILL) begin
        if (mh == 0 && mv == 0 && u_if.fifor_used_words >= PF) mst = RUN;
      end else if ((mh == HT - 1 && mv == VT - 1) || eurun) begin
        mst = WAIT_FILL;
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v) && n < 2 * FIELD) begin
      tick();
      n++;
    end
    check("run_until_reached", 32'(mh == h && mv == v), 32'd1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    mnib    = 4'd0;
    ack_cnt = 0;
    rst_n   = 1'b0;
    u_if.fifor_empty      = 1'b1;
    u_if.fifor_used_words = 9'd0;

    // Reset held for 3 clocks.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_video", 32'(video), 32'(LB));
      check("rst_sync", 32'(sync), 32'd1);
      check("rst_ack", 32'(u_if.fifor_acknowledge), 32'd0);
      check("rst_underrun", 32'(urun), 32'd0);
      check("rst_field_active", 32'(fact), 32'd0);
    end
    reset_model();
    rst_n = 1'b1;

    // Field A: FIFO empty, nothing armed, only sync activity.
    ack_cnt      = 0;
    sync_low_cnt = 0;
    run_cycles(FIELD);
    check("fieldA_acks", 32'(ack_cnt), 32'd0);
    check("fieldA_sync_lows", 32'(sync_low_cnt), 32'(VS * (HT - HS) + (VT - VS) * HS));

    // Field B: prefilled, full data field.
    u_if.fifor_used_words = 9'd256;
    u_if.fifor_empty      = 1'b0;
    ack_cnt = 0;
    run_until(0, VAS);
    a0 = ack_cnt;
    run_until(0, VAS + 1);
    check("line_acks", 32'(ack_cnt - a0), 32'(HAL - 4));
    run_until(0, 0);
    check("fieldB_acks", 32'(ack_cnt), 32'((HAL - 4) * VAL));

    // Field C: one below threshold at field start; raising mid-field must not arm.
    u_if.fifor_used_words = 9'd255;
    ack_cnt = 0;
    run_cycles(FIELD / 2);
    u_if.fifor_used_words = 9'd256;
    run_until(0, 0);
    check("fieldC_acks", 32'(ack_cnt), 32'd0);

    // Field D: underrun at data pixel 100 of line VAS+4.
    ack_cnt = 0;
    run_until(HAS + 4 + 100, VAS + 4);
    u_if.fifor_empty = 1'b1;
    tick();
    u_if.fifor_empty = 1'b0;
    run_until(0, 0);
    check("fieldD_acks", 32'(ack_cnt), 32'((HAL - 4) * 4 + 100));
    check("fieldD_underrun_sticky", 32'(urun), 32'd1);

    // Field E: re-arms after underrun, then reset mid-field.
    run_until(0, VAS + 9);
    check("fieldE_armed", 32'(fact), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_video", 32'(video), 32'(LB));
    check("midrst_sync", 32'(sync), 32'd1);
    check("midrst_underrun", 32'(urun), 32'd0);
    check("midrst_field_active", 32'(fact), 32'd0);

    // Counting restarts at (0,0) and arming is re-evaluated there.
    ack_cnt = 0;
    run_until(0, VAS + 1);
    check("post_rst_line_acks", 32'(ack_cnt), 32'(HAL - 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
